// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage pipeline: EX operand forwarding, load-use stall and a
// counted branch/loop Fetch-stall FSM. Define HAZARD_PERF_CNT_EN to add stall perf counters.
module hazard_ctrl_unit #(
    parameter int REG_AW       = 3,
    parameter int BR_STALL     = 2,
    parameter int R0_HARDWIRED = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_a_d,
    input  logic [REG_AW-1:0] rs_b_d,
    input  logic [REG_AW-1:0] rs_a_e,
    input  logic [REG_AW-1:0] rs_b_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              mem_read_e,
    input  logic              reg_write_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic              branch_d,
    input  logic              for_d,
    input  logic              br_resolved_e,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              br_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  lu_stall_cnt,
    output logic [CNT_W-1:0]  br_stall_cnt
`endif
);

    if (BR_STALL < 1 || BR_STALL > 255 || CNT_W < 1) begin : g_bad_param
        $error("hazard_ctrl_unit: BR_STALL must be 1..255 and CNT_W at least 1");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] BR_LOAD = 8'(BR_STALL - 1);

    state_t     state, next_state;
    logic [7:0] cnt, next_cnt;
    logic       lu;
    logic       fsm_stall;
    logic       fsm_flush;
    logic       fsm_busy;

    // Register 0 is a constant source when hardwired, so it never creates a dependency.
    function automatic logic nz(input logic [REG_AW-1:0] x);
        return (R0_HARDWIRED != 0) ? (x != '0) : 1'b1;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic [REG_AW-1:0] dm, input logic wm,
                                           input logic [REG_AW-1:0] dw, input logic ww);
        if (nz(src) && src == dm && wm)
            return 2'b10;
        else if (nz(src) && src == dw && ww)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign forward_a = fwd_sel(rs_a_e, rd_m, reg_write_m, rd_w, reg_write_w);
    assign forward_b = fwd_sel(rs_b_e, rd_m, reg_write_m, rd_w, reg_write_w);

    assign lu = mem_read_e && reg_write_e && nz(rd_e) && (rd_e == rs_a_d || rd_e == rs_b_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        fsm_stall  = 1'b0;
        fsm_flush  = 1'b0;
        fsm_busy   = 1'b0;
        case (state)
            IDLE: begin
                // A load-use hazard holds the branch in Decode; it is accepted next cycle.
                if ((branch_d || for_d) && !lu) begin
                    fsm_stall = 1'b1;
                    if (BR_STALL > 1 && !br_resolved_e) begin
                        next_state = BR_WAIT;
                        next_cnt   = BR_LOAD;
                    end
                end
            end
            BR_WAIT: begin
                fsm_stall = 1'b1;
                fsm_flush = 1'b1;
                fsm_busy  = 1'b1;
                next_cnt  = cnt - 8'd1;
                if (cnt == 8'd1 || br_resolved_e)
                    next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 8'd0;
            end
        endcase
    end

    // Flushing F/D overrides holding it, so stall_d drops whenever flush_d is raised.
    assign stall_f = !reset && (fsm_stall || lu);
    assign stall_d = !reset && lu && !fsm_flush;
    assign flush_d = !reset && fsm_flush;
    assign flush_e = !reset && lu;
    assign br_busy = !reset && fsm_busy;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_stall_cnt <= '0;
            br_stall_cnt <= '0;
        end else begin
            if (lu && lu_stall_cnt != '1)
                lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
            if (fsm_stall && br_stall_cnt != '1)
                br_stall_cnt <= br_stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: two instances (BR_STALL=3 and 4) share stimulus;
// expected output vectors are queued per step and compared at the falling edge.
module tb_hazard_ctrl_unit;

    localparam int AW = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rs_a_d, rs_b_d, rs_a_e, rs_b_e, rd_e, rd_m, rd_w;
    logic          mem_read_e, reg_write_e, reg_write_m, reg_write_w;
    logic          branch_d, for_d, br_resolved_e;

    logic [1:0] forward_a_3, forward_b_3, forward_a_4, forward_b_4;
    logic stall_f_3, stall_d_3, flush_d_3, flush_e_3, br_busy_3;
    logic stall_f_4, stall_d_4, flush_d_4, flush_e_4, br_busy_4;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] lu_cnt_3, br_cnt_3, lu_cnt_4, br_cnt_4;
`endif

    int errors = 0;
    int checks = 0;
    logic [8:0] exp3_q[$];
    logic [8:0] exp4_q[$];

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(AW), .BR_STALL(3), .R0_HARDWIRED(1), .CNT_W(CW)) u_dut3 (
        .clk(clk), .reset(reset),
        .rs_a_d(rs_a_d), .rs_b_d(rs_b_d), .rs_a_e(rs_a_e), .rs_b_e(rs_b_e),
        .rd_e(rd_e), .mem_read_e(mem_read_e), .reg_write_e(reg_write_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .branch_d(branch_d), .for_d(for_d), .br_resolved_e(br_resolved_e),
        .forward_a(forward_a_3), .forward_b(forward_b_3),
        .stall_f(stall_f_3), .stall_d(stall_d_3), .flush_d(flush_d_3),
        .flush_e(flush_e_3), .br_busy(br_busy_3)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_stall_cnt(lu_cnt_3), .br_stall_cnt(br_cnt_3)
`endif
    );

    hazard_ctrl_unit #(.REG_AW(AW), .BR_STALL(4), .R0_HARDWIRED(1), .CNT_W(CW)) u_dut4 (
        .clk(clk), .reset(reset),
        .rs_a_d(rs_a_d), .rs_b_d(rs_b_d), .rs_a_e(rs_a_e), .rs_b_e(rs_b_e),
        .rd_e(rd_e), .mem_read_e(mem_read_e), .reg_write_e(reg_write_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .branch_d(branch_d), .for_d(for_d), .br_resolved_e(br_resolved_e),
        .forward_a(forward_a_4), .forward_b(forward_b_4),
        .stall_f(stall_f_4), .stall_d(stall_d_4), .flush_d(flush_d_4),
        .flush_e(flush_e_4), .br_busy(br_busy_4)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_stall_cnt(lu_cnt_4), .br_stall_cnt(br_cnt_4)
`endif
    );

    // Vector layout: forward_a, forward_b, stall_f, stall_d, flush_d, flush_e, br_busy.
    function automatic logic [8:0] pk(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic sf, input logic sd, input logic fd,
                                      input logic fe, input logic bb);
        return {fa, fb, sf, sd, fd, fe, bb};
    endfunction

    task automatic clear_inputs();
        rs_a_d = '0; rs_b_d = '0; rs_a_e = '0; rs_b_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0;
        mem_read_e = 1'b0; reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        branch_d = 1'b0; for_d = 1'b0; br_resolved_e = 1'b0;
    endtask

    // One clock cycle: queue the expectations, compare at the falling edge, then move
    // just past the next rising edge so the caller can drive the following step.
    task automatic step(input string tag, input logic [8:0] e3, input logic [8:0] e4);
        logic [8:0] obs;
        logic [8:0] exp;
        exp3_q.push_back(e3);
        exp4_q.push_back(e4);
        @(negedge clk);
        obs = {forward_a_3, forward_b_3, stall_f_3, stall_d_3, flush_d_3, flush_e_3, br_busy_3};
        exp = exp3_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/bs3: got %b expected %b", tag, obs, exp);
        end
        obs = {forward_a_4, forward_b_4, stall_f_4, stall_d_4, flush_d_4, flush_e_4, br_busy_4};
        exp = exp4_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/bs4: got %b expected %b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic check_cnt(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] z;
        z = pk(2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Reset gates all stall/flush outputs; forwarding stays live.
        clear_inputs();
        reset = 1'b1;
        rs_a_e = 3'd3; rd_m = 3'd3; reg_write_m = 1'b1;
        mem_read_e = 1'b1; reg_write_e = 1'b1; rd_e = 3'd5; rs_a_d = 3'd5; branch_d = 1'b1;
        step("reset_gate", pk(2'b10, 2'b00, 0, 0, 0, 0, 0), pk(2'b10, 2'b00, 0, 0, 0, 0, 0));

        reset = 1'b0;
        clear_inputs();
        step("reset_state", z, z);

        // Forwarding priority and r0 suppression.
        rs_a_e = 3'd3; rs_b_e = 3'd3; rd_m = 3'd3; reg_write_m = 1'b1; rd_w = 3'd3; reg_write_w = 1'b1;
        step("fwd_mem", pk(2'b10, 2'b10, 0, 0, 0, 0, 0), pk(2'b10, 2'b10, 0, 0, 0, 0, 0));
        reg_write_m = 1'b0;
        step("fwd_wb", pk(2'b01, 2'b01, 0, 0, 0, 0, 0), pk(2'b01, 2'b01, 0, 0, 0, 0, 0));
        rs_a_e = 3'd0; rs_b_e = 3'd0; rd_m = 3'd0; reg_write_m = 1'b1; rd_w = 3'd0;
        step("fwd_r0", z, z);
        rs_a_e = 3'd2; rs_b_e = 3'd7; rd_m = 3'd7; rd_w = 3'd2;
        step("fwd_split", pk(2'b01, 2'b10, 0, 0, 0, 0, 0), pk(2'b01, 2'b10, 0, 0, 0, 0, 0));
        clear_inputs();

        // Load-use: one bubble, then the load has left Execute.
        mem_read_e = 1'b1; reg_write_e = 1'b1; rd_e = 3'd5; rs_b_d = 3'd5;
        step("lu_hit", pk(2'b00, 2'b00, 1, 1, 0, 1, 0), pk(2'b00, 2'b00, 1, 1, 0, 1, 0));
        clear_inputs();
        step("lu_release", z, z);
        mem_read_e = 1'b1; reg_write_e = 1'b1; rd_e = 3'd0; rs_a_d = 3'd0;
        step("lu_r0", z, z);
        rd_e = 3'd5; rs_a_d = 3'd4; rs_b_d = 3'd3;
        step("lu_nomatch", z, z);
        clear_inputs();

        // Full-length branch stall; a load-use inside BR_WAIT merges with the flush.
        branch_d = 1'b1;
        step("br_accept", pk(2'b00, 2'b00, 1, 0, 0, 0, 0), pk(2'b00, 2'b00, 1, 0, 0, 0, 0));
        branch_d = 1'b0;
        step("br_wait1", pk(2'b00, 2'b00, 1, 0, 1, 0, 1), pk(2'b00, 2'b00, 1, 0, 1, 0, 1));
        mem_read_e = 1'b1; reg_write_e = 1'b1; rd_e = 3'd6; rs_a_d = 3'd6;
        step("br_wait2_lu", pk(2'b00, 2'b00, 1, 0, 1, 1, 1), pk(2'b00, 2'b00, 1, 0, 1, 1, 1));
        clear_inputs();
        step("br_t3", z, pk(2'b00, 2'b00, 1, 0, 1, 0, 1));
        step("br_t4", z, z);

        // Early resolution in BR_WAIT, and resolution on the accept cycle itself.
        for_d = 1'b1;
        step("for_accept", pk(2'b00, 2'b00, 1, 0, 0, 0, 0), pk(2'b00, 2'b00, 1, 0, 0, 0, 0));
        for_d = 1'b0; br_resolved_e = 1'b1;
        step("for_resolve", pk(2'b00, 2'b00, 1, 0, 1, 0, 1), pk(2'b00, 2'b00, 1, 0, 1, 0, 1));
        br_resolved_e = 1'b0;
        step("for_released", z, z);
        branch_d = 1'b1; br_resolved_e = 1'b1;
        step("br_resolved_now", pk(2'b00, 2'b00, 1, 0, 0, 0, 0), pk(2'b00, 2'b00, 1, 0, 0, 0, 0));
        clear_inputs();
        step("br_no_wait", z, z);

        // Load-use and branch together: bubble first, branch accepted the cycle after.
        mem_read_e = 1'b1; reg_write_e = 1'b1; rd_e = 3'd2; rs_b_d = 3'd2; branch_d = 1'b1;
        step("coll_lu", pk(2'b00, 2'b00, 1, 1, 0, 1, 0), pk(2'b00, 2'b00, 1, 1, 0, 1, 0));
        mem_read_e = 1'b0; reg_write_e = 1'b0; rd_e = 3'd0;
        step("coll_accept", pk(2'b00, 2'b00, 1, 0, 0, 0, 0), pk(2'b00, 2'b00, 1, 0, 0, 0, 0));
        branch_d = 1'b0;
        step("coll_busy", pk(2'b00, 2'b00, 1, 0, 1, 0, 1), pk(2'b00, 2'b00, 1, 0, 1, 0, 1));

        // Reset while both instances are still in BR_WAIT.
        reset = 1'b1;
        step("rst_mid_wait", z, z);
        reset = 1'b0;
        step("rst_after", z, z);
`ifdef HAZARD_PERF_CNT_EN
        check_cnt("lu_cnt3_rst", lu_cnt_3, '0);
        check_cnt("br_cnt4_rst", br_cnt_4, '0);
`endif
        mem_read_e = 1'b1; reg_write_e = 1'b1; rd_e = 3'd4; rs_a_d = 3'd4;
        step("lu_again", pk(2'b00, 2'b00, 1, 1, 0, 1, 0), pk(2'b00, 2'b00, 1, 1, 0, 1, 0));
        clear_inputs();
        step("idle_end", z, z);
`ifdef HAZARD_PERF_CNT_EN
        check_cnt("lu_cnt4_one", lu_cnt_4, CW'(1));
        check_cnt("br_cnt3_zero", br_cnt_3, '0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the pipeline hazard unit.
- Provides EX-stage operand forwarding selects and real load-use detection (one-bubble stall).
- Adds a counter-based branch/loop stall FSM that holds Fetch for a configurable number of cycles, with early release on branch resolution.
- Sits beside the 5-stage datapath; drives the F/D pipeline-register enables, the D/E flushes, and the EX operand muxes.

Parameters:
REG_AW, 3, register-address width
BR_STALL, 2, Fetch-stall cycles per branch/loop instruction (legal range 1..255)
R0_HARDWIRED, 1, when 1 register 0 is never forwarded or hazard-checked
CNT_W, 16, perf-counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
rs_a_d  in  REG_AW  source A of instruction in Decode
rs_b_d  in  REG_AW  source B of instruction in Decode
rs_a_e  in  REG_AW  source A of instruction in Execute
rs_b_e  in  REG_AW  source B of instruction in Execute
rd_e  in  REG_AW  destination in Execute
mem_read_e  in  1  Execute instruction is a load
reg_write_e  in  1  Execute instruction writes a register
rd_m  in  REG_AW  destination in Memory
reg_write_m  in  1  Memory instruction writes a register
rd_w  in  REG_AW  destination in Writeback
reg_write_w  in  1  Writeback instruction writes a register
branch_d  in  1  branch in Decode
for_d  in  1  loop (FOR) instruction in Decode
br_resolved_e  in  1  branch/loop outcome known this cycle
forward_a  out  2  10=from MEM, 01=from WB, 00=register file
forward_b  out  2  same encoding, source B
stall_f  out  1  hold PC / Fetch register
stall_d  out  1  hold F/D register
flush_d  out  1  clear F/D register (bubble into Decode)
flush_e  out  1  clear D/E register (bubble into Execute)
br_busy  out  1  FSM in BR_WAIT

Behaviour:
- Reset (sync, active-high): state=IDLE, cnt=0. While reset is high, stall_f/stall_d/flush_d/flush_e/br_busy=0; forward selects remain combinational.
- nz(x) = (x!=0) when R0_HARDWIRED=1, else 1.
- Forwarding (combinational), evaluated for A and B independently:
  - 10 if nz(src) & src==rd_m & reg_write_m.
  - else 01 if nz(src) & src==rd_w & reg_write_w.
  - else 00.
  - MEM has priority over WB.
- Load-use (combinational): lu = mem_read_e & reg_write_e & nz(rd_e) & (rd_e==rs_a_d | rd_e==rs_b_d).
  - When lu=1: stall_f=1, stall_d=1, flush_e=1 for that cycle only. No state change.
- Branch FSM, states IDLE and BR_WAIT, 8-bit down-counter cnt.
  - IDLE, (branch_d|for_d) & !lu: stall_f=1, stall_d=0, so the branch advances to Execute and Fetch holds.
    - If BR_STALL>1 and !br_resolved_e: cnt<=BR_STALL-1, go to BR_WAIT.
    - Otherwise stay in IDLE.
  - IDLE, (branch_d|for_d) & lu: lu takes priority. FSM does not start; the branch is re-evaluated next cycle.
  - BR_WAIT: stall_f=1, flush_d=1, br_busy=1; branch_d/for_d ignored; cnt<=cnt-1.
    - If cnt==1 or br_resolved_e: go to IDLE next cycle.
    - br_resolved_e releases on the same-cycle edge.
  - lu during BR_WAIT: combine by OR; flush_e also asserts.
  - stall_d and flush_d are never both 1. If both would be requested, flush_d wins.
- Worst-case Fetch stall per branch: BR_STALL cycles.
- Reset asserted mid-BR_WAIT: next edge forces IDLE, cnt=0; no residual stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs lu_stall_cnt[CNT_W-1:0] and br_stall_cnt[CNT_W-1:0].
  - lu_stall_cnt increments each cycle lu=1.
  - br_stall_cnt increments each cycle the FSM causes stall_f (IDLE accept cycle plus BR_WAIT).
  - Both saturate at all-ones and clear on reset.
- Undefined: ports and logic absent; all other behaviour is identical.

Test Plan:
- Forward priority: rs_a_e=3, rd_m=3, reg_write_m=1, rd_w=3, reg_write_w=1 -> forward_a=10. Drop reg_write_m -> 01. rs_a_e=0, rd_m=0, R0_HARDWIRED=1 -> 00.
- Load-use: mem_read_e=1, reg_write_e=1, rd_e=5, rs_b_d=5 -> stall_f=stall_d=flush_e=1 for exactly one cycle. Same with rd_e=0 -> no stall.
- Branch, BR_STALL=3, br_resolved_e=0: branch_d pulse at cycle t -> stall_f=1 at t, t+1, t+2; flush_d=1 and br_busy=1 at t+1, t+2; all 0 at t+3.
- Early resolve, BR_STALL=4: for_d at t, br_resolved_e=1 at t+1 -> BR_WAIT only at t+1; stall_f=0 at t+2.
- Collision: lu=1 and branch_d=1 at t -> load-use response only at t; FSM starts at t+1 (br_busy=1 at t+2).
- Reset mid-wait: reset=1 at t+1 of a BR_STALL=4 branch -> all stall/flush outputs 0 after the edge; counters 0 when HAZARD_PERF_CNT_EN is defined.
